// File: rtl/fetch_stall_ctrl.sv
// Memory-side fetch responder: multi-cycle access model, redirect abort, end-of-program drain and halt.
// Optional busy-cycle statistics enabled by defining FETCH_STALL_STATS_EN.
module fetch_stall_ctrl #(
    parameter int unsigned LATENCY      = 4,
    parameter logic [31:0] HALT_PC      = 32'h80088008,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] next_pc,
    input  logic        jbr_taken,
    output logic        stall,
    output logic        fetch_valid,
    output logic [31:0] fetch_addr,
    output logic        halt,
    output logic [31:0] busy_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN,
        S_HALTED
    } state_t;

    localparam logic [7:0] WAIT_LAST  = 8'(LATENCY - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  drain_cnt_q, drain_cnt_d;
    logic        stall_d, fetch_valid_d, halt_d;
    logic [31:0] fetch_addr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            drain_cnt_q <= '0;
            stall       <= 1'b0;
            fetch_valid <= 1'b0;
            halt        <= 1'b0;
            fetch_addr  <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            stall       <= stall_d;
            fetch_valid <= fetch_valid_d;
            halt        <= halt_d;
            fetch_addr  <= fetch_addr_d;
        end
    end

    // Outputs are computed as next-cycle values so every port is a flop.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        stall_d       = 1'b0;
        fetch_valid_d = 1'b0;
        halt_d        = 1'b0;
        fetch_addr_d  = fetch_addr;
        unique case (state_q)
            S_IDLE: begin
                if (req && next_pc == HALT_PC) begin
                    fetch_addr_d = next_pc;
                    drain_cnt_d  = '0;
                    state_d      = S_DRAIN;
                end else if (req) begin
                    fetch_addr_d = next_pc;
                    wait_cnt_d   = '0;
                    stall_d      = 1'b1;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                // A redirect beats completion, even on the last wait cycle.
                if (jbr_taken) begin
                    state_d = S_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    fetch_valid_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    stall_d    = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    halt_d  = 1'b1;
                    stall_d = 1'b1;
                    state_d = S_HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q + 8'd1;
                end
            end
            S_HALTED: begin
                halt_d  = 1'b1;
                stall_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef FETCH_STALL_STATS_EN
    logic [31:0] busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else if (state_q == S_WAIT && busy_q != '1) begin
            busy_q <= busy_q + 32'd1;
        end
    end

    assign busy_cycles = busy_q;
`else
    assign busy_cycles = '0;
`endif

endmodule

// File: doc/fetch_stall_ctrl.md
Name: fetch_stall_ctrl

Overview:
- Memory-side responder for the pipelined MIPS core's fetch interface.
- Accepts the core's fetch request and models a multi-cycle memory.
- Generates the `stall` input the core consumes and aborts an in-flight access on a taken jump/branch.
- Detects the end-of-program PC and, after a pipeline drain, freezes the core with a sticky `halt`. Replaces ad-hoc stall logic in benches and top-level simulation wrappers.

Parameters:
- LATENCY, 4, wait cycles per access (legal range 1..255; 8-bit counter).
- HALT_PC, 32'h80088008, fetch address that marks program end.
- DRAIN_CYCLES, 2, cycles allowed for in-flight instructions to retire after HALT_PC is seen (legal range 0..255).

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req  in  1  core requests a fetch at next_pc this cycle
- next_pc  in  32  fetch address from the core
- jbr_taken  in  1  core redirect (jump/branch taken); aborts an in-flight access
- stall  out  1  registered; holds the core pipeline
- fetch_valid  out  1  registered one-cycle pulse: access at fetch_addr complete
- fetch_addr  out  32  address of the current/last accepted access
- halt  out  1  sticky end-of-program flag
- busy_cycles  out  32  count of WAIT-state stall cycles (see Optional Feature)

Behaviour:
- Reset: synchronous, active-high, on `rst`, with priority over all other inputs, including mid-access or when HALTED.
  - state=IDLE; stall=0, fetch_valid=0, fetch_addr=0, halt=0, busy_cycles=0; wait and drain counters=0.
- States: IDLE, WAIT, DRAIN, HALTED. All outputs are registered.
- IDLE:
  - If req && next_pc==HALT_PC: latch fetch_addr; go DRAIN (drain_cnt=0); stall stays 0.
  - Else if req: latch fetch_addr=next_pc; go WAIT; wait_cnt=0; stall=1.
  - Else hold; stall=0.
  - jbr_taken without req in IDLE is ignored.
- WAIT:
  - stall=1; wait_cnt increments each cycle.
  - When wait_cnt==LATENCY-1 at the edge: go IDLE; stall=0; fetch_valid=1 for exactly one cycle.
  - Net: req sampled at edge N gives stall high for cycles N..N+LATENCY-1 and fetch_valid high in cycle N+LATENCY.
  - LATENCY=1: a single stall cycle.
- Abort:
  - jbr_taken in WAIT (including the final count cycle) has priority over completion.
  - Next edge: IDLE, stall=0, no fetch_valid pulse; fetch_addr unchanged.
  - A new req arriving in that IDLE cycle is accepted normally.
- Back-to-back: req present in the cycle fetch_valid=1 is accepted. State returns to WAIT at the next edge, so stall drops for exactly one cycle between accesses.
- DRAIN:
  - stall=0; drain_cnt increments each cycle; req and jbr_taken are ignored.
  - When drain_cnt==DRAIN_CYCLES: go HALTED. DRAIN_CYCLES=0 means HALTED one cycle after DRAIN entry.
- HALTED: halt=1, stall=1, held until rst; all inputs except rst are ignored.
- fetch_valid is never asserted in DRAIN or HALTED.
- busy_cycles:
  - Increments in every cycle where state==WAIT.
  - Saturates at 32'hFFFFFFFF with no wrap.
  - Does not count HALTED stall.

Optional Feature:
- Macro FETCH_STALL_STATS_EN.
- Defined: busy_cycles counter implemented as above.
- Undefined: counter logic omitted; busy_cycles tied to 32'h0; all other behaviour identical.

Test Plan:
- Reset, then req=1, next_pc=32'h00400000 for one cycle (LATENCY=4) -> stall=1 for 4 cycles, then fetch_valid=1 for 1 cycle with fetch_addr=32'h00400000; busy_cycles=4.
- req held high continuously, next_pc incrementing by 4 -> repeating pattern of stall 4 cycles high / 1 low; fetch_valid pulses every 5 cycles; addresses in order 0x00400000, 0x00400004, ...
- req at 0x00400008, jbr_taken=1 in the 2nd stall cycle -> stall=0 next cycle, no fetch_valid; then req at 0x00400100 completes normally after 4 stall cycles.
- jbr_taken coincident with the final wait cycle -> abort wins; no fetch_valid pulse.
- req with next_pc=32'h80088008 (DRAIN_CYCLES=2) -> stall=0 for the drain cycles, then halt=1 and stall=1 held; further req/jbr_taken have no effect; rst=1 for one cycle clears halt, stall and busy_cycles to 0.
- rst asserted in the 3rd WAIT cycle -> next cycle stall=0, fetch_valid=0, state IDLE; with FETCH_STALL_STATS_EN undefined, busy_cycles reads 0 throughout.
